// File: rtl/life_grid_engine_pkg.sv
// Shared types for the Life grid engine: FSM states, plot colours, index-to-coordinate helper.
// Pure declarations, no latency, no flow control.
package life_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLOT1,
    COMPUTE,
    COMMIT,
    DRAW,
    WAIT
  } state_t;

  localparam logic [2:0] COLOUR_ALIVE = 3'b111;
  localparam logic [2:0] COLOUR_DEAD  = 3'b000;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } xy_t;

  // Raster index to zero-extended plot coordinates; xb is log2 of the grid width.
  function automatic xy_t idx2xy(input logic [11:0] idx, input int xb);
    xy_t         r;
    logic [11:0] m;
    m   = (12'd1 << xb) - 12'd1;
    r.x = 8'(idx & m);
    r.y = 7'(idx >> xb);
    return r;
  endfunction

endpackage

// File: rtl/life_grid_engine_if.sv
// Plot request bus from the grid engine to the VGA plotter.
// Valid/ready: a transfer happens on each edge where both are high.
interface life_grid_engine_if;
  logic       plot_valid;
  logic       plot_ready;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;

  modport master (output plot_valid, plot_x, plot_y, plot_colour, input plot_ready);
  modport slave  (input plot_valid, plot_x, plot_y, plot_colour, output plot_ready);
endinterface

// File: rtl/life_grid_engine_neighbour_count.sv
// Counts the 8 live neighbours of cell (x,y) on a torus; combinational, zero latency.
// Power-of-2 grid sizes let coordinate wrap fall out of natural overflow.
module life_neighbour_count #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16
) (
  input  logic [GRID_W*GRID_H-1:0]  cur,
  input  logic [$clog2(GRID_W)-1:0] x,
  input  logic [$clog2(GRID_H)-1:0] y,
  output logic [3:0]                count
);
  localparam int XB = $clog2(GRID_W);
  localparam int YB = $clog2(GRID_H);

  logic [XB-1:0] xn;
  logic [YB-1:0] yn;

  always_comb begin
    count = 4'd0;
    xn    = x;
    yn    = y;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx != 0 || dy != 0) begin
          xn    = x + XB'(dx);
          yn    = y + YB'(dy);
          count = count + 4'(cur[{yn, xn}]);
        end
      end
    end
  end
endmodule

// File: rtl/life_grid_engine.sv
// Game-of-Life datapath: seeds cells, computes one cell/cycle (N cycles/gen), streams the frame.
// Plot output is registered and holds while stalled; full throughput with plot_ready held high.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 16,
  parameter int GEN_DELAY = 1_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           loadVal,
  input  logic                 ldX,
  input  logic                 ldY,
  input  logic                 load,
  input  logic                 start,
  life_grid_engine_if.master   plot,
  output logic                 busy,
  output logic [15:0]          generation
);
  localparam int XB = $clog2(GRID_W);
  localparam int YB = $clog2(GRID_H);
  localparam int AB = XB + YB;
  localparam int N  = GRID_W * GRID_H;
  localparam logic [AB-1:0] LAST  = AB'(N - 1);
  localparam logic [31:0]   DLAST = 32'(GEN_DELAY - 1);

  state_t        state, state_d;
  logic [XB-1:0] x_reg;
  logic [YB-1:0] y_reg;
  logic [N-1:0]  cur, nxt;
  logic [AB-1:0] idx, idx_inc;
  logic [31:0]   wait_cnt;
  logic          stop_seen;
  logic [3:0]    n_count;
  logic          accept, last_idx, nxt_cell;
  xy_t           nxt_xy;

  assign accept   = plot.plot_valid && plot.plot_ready;
  assign last_idx = (idx == LAST);
  assign idx_inc  = idx + AB'(1);
  assign busy     = (state != IDLE) && (state != WAIT);
  assign nxt_xy   = idx2xy(12'(idx_inc), XB);

  life_neighbour_count #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_count (
    .cur   (cur),
    .x     (idx[XB-1:0]),
    .y     (idx[AB-1:XB]),
    .count (n_count)
  );

  assign nxt_cell = (n_count == 4'd3) || (cur[idx] && (n_count == 4'd2));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // A start drop seen anywhere in the generation sends the FSM home after the draw.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (load) state_d = PLOT1;
               else if (start) state_d = COMPUTE;
      PLOT1:   if (accept) state_d = IDLE;
      COMPUTE: if (last_idx) state_d = COMMIT;
      COMMIT:  state_d = DRAW;
      DRAW:    if (accept && last_idx) state_d = (start && !stop_seen) ? WAIT : IDLE;
      WAIT:    if (!start) state_d = IDLE;
               else if (wait_cnt == DLAST) state_d = COMPUTE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_reg            <= '0;
      y_reg            <= '0;
      cur              <= '0;
      nxt              <= '0;
      idx              <= '0;
      wait_cnt         <= '0;
      stop_seen        <= 1'b0;
      generation       <= '0;
      plot.plot_valid  <= 1'b0;
      plot.plot_x      <= '0;
      plot.plot_y      <= '0;
      plot.plot_colour <= COLOUR_DEAD;
    end else begin
      case (state)
        IDLE: begin
          idx       <= '0;
          stop_seen <= 1'b0;
          if (ldX) x_reg <= loadVal[XB-1:0];
          if (ldY) y_reg <= loadVal[YB-1:0];
          if (load) begin
            cur[{y_reg, x_reg}] <= 1'b1;
            plot.plot_valid     <= 1'b1;
            plot.plot_x         <= 8'(x_reg);
            plot.plot_y         <= 7'(y_reg);
            plot.plot_colour    <= COLOUR_ALIVE;
          end
        end
        PLOT1: if (accept) plot.plot_valid <= 1'b0;
        COMPUTE: begin
          nxt[idx] <= nxt_cell;
          idx      <= idx_inc;
          if (!start) stop_seen <= 1'b1;
        end
        COMMIT: begin
          // cur updates on this edge, so the first pixel comes straight from nxt.
          cur              <= nxt;
          generation       <= generation + 16'd1;
          plot.plot_valid  <= 1'b1;
          plot.plot_x      <= '0;
          plot.plot_y      <= '0;
          plot.plot_colour <= nxt[0] ? COLOUR_ALIVE : COLOUR_DEAD;
          if (!start) stop_seen <= 1'b1;
        end
        DRAW: begin
          wait_cnt <= '0;
          if (!start) stop_seen <= 1'b1;
          if (accept) begin
            if (last_idx) begin
              plot.plot_valid <= 1'b0;
              idx             <= '0;
            end else begin
              idx              <= idx_inc;
              plot.plot_x      <= nxt_xy.x;
              plot.plot_y      <= nxt_xy.y;
              plot.plot_colour <= cur[idx_inc] ? COLOUR_ALIVE : COLOUR_DEAD;
            end
          end
        end
        WAIT: begin
          wait_cnt  <= wait_cnt + 32'd1;
          idx       <= '0;
          stop_seen <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
